// File: rtl/mux_n_scan.sv
// N-channel registered multiplexer with manual select and an auto-scan mode
// that steps through every channel, holding each one for DWELL enabled cycles.
module mux_n_scan #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int DWELL = 2,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    input  logic               en,
    output logic [WIDTH-1:0]   y,
    output logic [SEL_W-1:0]   ch,
    output logic               valid,
    output logic               wrap,
    output logic               err
);
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W:0]   N_L   = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N-1);
    localparam logic [DW_W-1:0]  DLAST = DW_W'(DWELL-1);

    typedef enum logic {MANUAL, SCAN} state_t;

    state_t                      state;
    logic [N-1:0][WIDTH-1:0]     chan;
    logic [SEL_W-1:0]            cnt, eff_cnt;
    logic [DW_W-1:0]             dcnt, eff_dcnt;
    logic                        pend, eff_pend;
    logic                        sel_ok;

    // channel 0 sits at the MSBs of the packed input
    for (genvar i = 0; i < N; i++) begin : g_chan
        assign chan[i] = data[(N-1-i)*WIDTH +: WIDTH];
    end

    // On the first SCAN cycle the counters act as if already reloaded, so
    // sampling starts at channel 0 in the same cycle mode rises.
    always_comb begin
        eff_cnt  = cnt;
        eff_dcnt = dcnt;
        eff_pend = pend;
        if (state == MANUAL) begin
            eff_cnt  = '0;
            eff_dcnt = '0;
            eff_pend = 1'b0;
        end
        sel_ok = ({1'b0, sel} < N_L);
    end

    // pend remembers an N-1 -> 0 advance so wrap lines up with channel 0 on y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MANUAL;
            cnt   <= '0;
            dcnt  <= '0;
            pend  <= 1'b0;
            y     <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= mode ? SCAN : MANUAL;
            valid <= 1'b0;
            wrap  <= 1'b0;
            if (mode) begin
                cnt  <= eff_cnt;
                dcnt <= eff_dcnt;
                pend <= eff_pend;
                if (en) begin
                    y     <= chan[eff_cnt];
                    ch    <= eff_cnt;
                    valid <= 1'b1;
                    wrap  <= eff_pend;
                    pend  <= 1'b0;
                    if (eff_dcnt == DLAST) begin
                        dcnt <= '0;
                        if (eff_cnt == LAST) begin
                            cnt  <= '0;
                            pend <= 1'b1;
                        end else begin
                            cnt <= eff_cnt + 1'b1;
                        end
                    end else begin
                        dcnt <= eff_dcnt + 1'b1;
                    end
                end
            end else if (en) begin
                if (sel_ok) begin
                    y     <= chan[sel];
                    ch    <= sel;
                    valid <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mux_n_scan.sv
// Bench for mux_n_scan: a 4-channel/DWELL=2 and a 3-channel/DWELL=1 instance
// share stimulus and are checked against a position-based scan model.
module tb_mux_n_scan;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_a = '0;
    logic [23:0] data_b = '0;
    logic [1:0]  sel = '0;
    logic        mode = 1'b0, en = 1'b0;
    logic [7:0]  ya, yb;
    logic [1:0]  cha, chb;
    logic        va, wa, ea, vb, wb, eb;

    always #5 clk = ~clk;

    mux_n_scan #(.N(4), .WIDTH(8), .DWELL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .data(data_a), .sel(sel), .mode(mode), .en(en),
        .y(ya), .ch(cha), .valid(va), .wrap(wa), .err(ea));
    mux_n_scan #(.N(3), .WIDTH(8), .DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .data(data_b), .sel(sel), .mode(mode), .en(en),
        .y(yb), .ch(chb), .valid(vb), .wrap(wb), .err(eb));

    typedef struct {
        int         pos;
        bit         scan;
        logic [7:0] y;
        logic [1:0] ch;
        logic       valid, wrap, err;
    } model_t;

    model_t ma, mb;
    int n_cmp = 0, n_bad = 0;

    function automatic model_t mreset();
        model_t m;
        m.pos = 0; m.scan = 0; m.y = '0; m.ch = '0;
        m.valid = 0; m.wrap = 0; m.err = 0;
        return m;
    endfunction

    // pos = enabled scan samples since entering scan; channel and wrap follow from it
    function automatic model_t mstep(model_t mi, int n, int dw, logic md, logic e,
                                     logic [1:0] s, logic [31:0] d);
        model_t m = mi;
        m.valid = 0;
        m.wrap  = 0;
        if (md) begin
            if (!m.scan) m.pos = 0;
            if (e) begin
                int c;
                c = (m.pos / dw) % n;
                m.y     = 8'(d >> (8 * (n - 1 - c)));
                m.ch    = 2'(c);
                m.valid = 1;
                m.wrap  = (m.pos > 0) && (m.pos % (n * dw) == 0);
                m.pos++;
            end
        end else if (e) begin
            if (int'(s) < n) begin
                m.y     = 8'(d >> (8 * (n - 1 - int'(s))));
                m.ch    = s;
                m.valid = 1;
            end else begin
                m.err = 1;
            end
        end
        m.scan = md;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            ma = mstep(ma, 4, 2, mode, en, sel, data_a);
            mb = mstep(mb, 3, 1, mode, en, sel, {8'h00, data_b});
        end else begin
            ma = mreset();
            mb = mreset();
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        mode = 1'b0; en = 1'b0; sel = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        mode = 1'b1; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_a = $urandom; data_b = 24'($urandom);
            sel = 2'($urandom);
            tick();
        end
        mode = 1'b0; sel = 2'd3; tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ya, cha, va, wa, ea} !== 13'h0) begin
            n_bad++; $display("FAIL reset_a got=%h exp=0", {ya, cha, va, wa, ea});
        end
        n_cmp++;
        if ({yb, chb, vb, wb, eb} !== 13'h0) begin
            n_bad++; $display("FAIL reset_b got=%h exp=0", {yb, chb, vb, wb, eb});
        end
        ma = mreset(); mb = mreset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        logic [7:0] want [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        data_a = 32'hA0B1C2D3; data_b = 24'hA0B1C2;
        mode = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            n_cmp++;
            if ({ya, cha, va, wa, ea} !== {want[i], 2'(i), 3'b100}) begin
                n_bad++; $display("FAIL manual_a sel=%0d got=%h exp=%h", i,
                                  {ya, cha, va, wa, ea}, {want[i], 2'(i), 3'b100});
            end
            n_cmp++;
            if ({yb, chb, vb, wb, eb} !== {mb.y, mb.ch, mb.valid, mb.wrap, mb.err}) begin
                n_bad++; $display("FAIL manual_b sel=%0d got=%h exp=%h", i,
                                  {yb, chb, vb, wb, eb}, {mb.y, mb.ch, mb.valid, mb.wrap, mb.err});
            end
        end
    endtask

    task automatic test_scan();
        logic [7:0] want [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        apply_reset();
        data_a = 32'hA0B1C2D3; data_b = 24'hA0B1C2;
        mode = 1'b1; en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            n_cmp++;
            if ({ya, cha, va, wa} !== {want[(i/2)%4], 2'((i/2)%4), 1'b1, i == 8 || i == 16}) begin
                n_bad++; $display("FAIL scan_a i=%0d got=%h exp=%h", i, {ya, cha, va, wa},
                                  {want[(i/2)%4], 2'((i/2)%4), 1'b1, i == 8 || i == 16});
            end
            n_cmp++;
            if ({yb, chb, vb, wb, eb} !== {mb.y, mb.ch, mb.valid, mb.wrap, mb.err}) begin
                n_bad++; $display("FAIL scan_b i=%0d got=%h exp=%h", i,
                                  {yb, chb, vb, wb, eb}, {mb.y, mb.ch, mb.valid, mb.wrap, mb.err});
            end
        end
    endtask

    task automatic test_pause();
        logic [7:0] want [8] = '{8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hC2};
        logic       wv   [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_reset();
        data_a = 32'hA0B1C2D3;
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en = (i < 3 || i > 5);
            tick();
            n_cmp++;
            if ({ya, va} !== {want[i], wv[i]}) begin
                n_bad++; $display("FAIL pause_a i=%0d got y=%h v=%b exp y=%h v=%b",
                                  i, ya, va, want[i], wv[i]);
            end
            n_cmp++;
            if ({yb, chb, vb, wb, eb} !== {mb.y, mb.ch, mb.valid, mb.wrap, mb.err}) begin
                n_bad++; $display("FAIL pause_b i=%0d got=%h exp=%h", i,
                                  {yb, chb, vb, wb, eb}, {mb.y, mb.ch, mb.valid, mb.wrap, mb.err});
            end
        end
    endtask

    task automatic test_out_of_range();
        apply_reset();
        data_b = 24'hA0B1C2; data_a = 32'hA0B1C2D3;
        mode = 1'b0; en = 1'b1;
        sel = 2'd2; tick();
        sel = 2'd3; tick();
        n_cmp++;
        if ({yb, chb, vb, wb, eb} !== {8'hC2, 2'd2, 3'b001}) begin
            n_bad++; $display("FAIL oor_b got=%h exp=%h", {yb, chb, vb, wb, eb}, {8'hC2, 2'd2, 3'b001});
        end
        sel = 2'd0; tick();
        n_cmp++;
        if ({yb, chb, vb, wb, eb} !== {8'hA0, 2'd0, 3'b101}) begin
            n_bad++; $display("FAIL oor_sticky_b got=%h exp=%h", {yb, chb, vb, wb, eb}, {8'hA0, 2'd0, 3'b101});
        end
        n_cmp++;
        if (ea !== 1'b0) begin
            n_bad++; $display("FAIL oor_a_err got=%b exp=0", ea);
        end
    endtask

    task automatic test_mode_switch();
        apply_reset();
        data_a = 32'hA0B1C2D3;
        mode = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (ya !== 8'hC2) begin
            n_bad++; $display("FAIL msw_at2 got=%h exp=c2", ya);
        end
        mode = 1'b0; sel = 2'd1; tick();
        n_cmp++;
        if ({ya, cha, va, wa} !== {8'hB1, 2'd1, 2'b10}) begin
            n_bad++; $display("FAIL msw_manual got=%h exp=%h", {ya, cha, va, wa}, {8'hB1, 2'd1, 2'b10});
        end
        mode = 1'b1; tick();
        n_cmp++;
        if ({ya, cha, va, wa} !== {8'hA0, 2'd0, 2'b10}) begin
            n_bad++; $display("FAIL msw_restart got=%h exp=%h", {ya, cha, va, wa}, {8'hA0, 2'd0, 2'b10});
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) mode = ~mode;
            en     = ($urandom_range(3) != 0);
            sel    = 2'($urandom);
            data_a = $urandom;
            data_b = 24'($urandom);
            if ($urandom_range(150) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            tick();
            n_cmp++;
            if ({ya, cha, va, wa, ea} !== {ma.y, ma.ch, ma.valid, ma.wrap, ma.err}) begin
                n_bad++; $display("FAIL rand_a i=%0d got=%h exp=%h", i,
                                  {ya, cha, va, wa, ea}, {ma.y, ma.ch, ma.valid, ma.wrap, ma.err});
            end
            n_cmp++;
            if ({yb, chb, vb, wb, eb} !== {mb.y, mb.ch, mb.valid, mb.wrap, mb.err}) begin
                n_bad++; $display("FAIL rand_b i=%0d got=%h exp=%h", i,
                                  {yb, chb, vb, wb, eb}, {mb.y, mb.ch, mb.valid, mb.wrap, mb.err});
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        ma = mreset(); mb = mreset();
        tick(); tick();
        rst_n = 1'b1;
        test_reset();
        test_manual();
        test_scan();
        test_pause();
        test_out_of_range();
        test_mode_switch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
